// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions for the ID/EX pipeline stage: ALU opcode encodings,
// operand-select constants and the bypass-hit helper.
package id_ex_stage_pkg;

    localparam int REG_ADDR_W = 5;

    // ALU opcode encodings; the ALU owns their meaning, this stage only passes them on.
    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00010,
        ALU_SLT  = 5'b00100,
        ALU_SLTU = 5'b00101,
        ALU_AND  = 5'b01001,
        ALU_OR   = 5'b01010,
        ALU_XOR  = 5'b01011,
        ALU_SLL  = 5'b01110,
        ALU_SRL  = 5'b01111,
        ALU_SRA  = 5'b10000,
        ALU_SRC0 = 5'b10001,
        ALU_SRC1 = 5'b10010
    } alu_op_e;

    // Operand source selects.
    localparam logic SRC0_RS1 = 1'b0;
    localparam logic SRC0_PC  = 1'b1;
    localparam logic SRC1_RS2 = 1'b0;
    localparam logic SRC1_IMM = 1'b1;

    // A later stage supplies a value for register ra; x0 is hard-wired and never bypassed.
    function automatic logic bypass_hit(input logic                  we,
                                        input logic [REG_ADDR_W-1:0] wa,
                                        input logic [REG_ADDR_W-1:0] ra);
        return we && (wa != '0) && (wa == ra);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID-side, bypass and EX-side signals of the ID/EX stage.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
);
    import id_ex_stage_pkg::*;

    // Pipeline control
    logic                  stall;
    logic                  flush;

    // Decode-stage instruction
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_rd0;
    logic [DATA_WIDTH-1:0] id_rd1;
    logic [DATA_WIDTH-1:0] id_imm;
    logic [REG_ADDR_W-1:0] id_ra0;
    logic [REG_ADDR_W-1:0] id_ra1;
    logic [REG_ADDR_W-1:0] id_wa;
    logic                  id_we;
    logic                  id_mem_re;
    logic [OP_WIDTH-1:0]   id_alu_op;
    logic                  id_src0_sel;
    logic                  id_src1_sel;

    // Bypass sources from later stages
    logic                  mem_we;
    logic [REG_ADDR_W-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_wa;
    logic [DATA_WIDTH-1:0] wb_wd;

    // Execute-stage outputs
    logic [DATA_WIDTH-1:0] alu_src0;
    logic [DATA_WIDTH-1:0] alu_src1;
    logic [OP_WIDTH-1:0]   alu_op;
    logic                  ex_valid;
    logic                  ex_we;
    logic                  ex_mem_re;
    logic [REG_ADDR_W-1:0] ex_wa;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_store_data;
    logic                  load_use;

    modport master (
        output stall, flush,
        output id_valid, id_pc, id_rd0, id_rd1, id_imm, id_ra0, id_ra1, id_wa,
        output id_we, id_mem_re, id_alu_op, id_src0_sel, id_src1_sel,
        output mem_we, mem_wa, mem_wd, wb_we, wb_wa, wb_wd,
        input  alu_src0, alu_src1, alu_op, ex_valid, ex_we, ex_mem_re,
        input  ex_wa, ex_pc, ex_store_data, load_use
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_pc, id_rd0, id_rd1, id_imm, id_ra0, id_ra1, id_wa,
        input  id_we, id_mem_re, id_alu_op, id_src0_sel, id_src1_sel,
        input  mem_we, mem_wa, mem_wd, wb_we, wb_wa, wb_wd,
        output alu_src0, alu_src1, alu_op, ex_valid, ex_we, ex_mem_re,
        output ex_wa, ex_pc, ex_store_data, load_use
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Two-level operand bypass: MEM-stage result first, then WB-stage result,
// otherwise the register-file value captured at issue.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [REG_ADDR_W-1:0] ra_i,
    input  logic [DATA_WIDTH-1:0] rd_i,
    input  logic                  mem_we_i,
    input  logic [REG_ADDR_W-1:0] mem_wa_i,
    input  logic [DATA_WIDTH-1:0] mem_wd_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_wa_i,
    input  logic [DATA_WIDTH-1:0] wb_wd_i,
    output logic [DATA_WIDTH-1:0] fwd_o
);

    // Youngest producer wins, so MEM is checked before WB.
    always_comb begin
        fwd_o = rd_i;
        if (bypass_hit(mem_we_i, mem_wa_i, ra_i)) begin
            fwd_o = mem_wd_i;
        end else if (bypass_hit(wb_we_i, wb_wa_i, ra_i)) begin
            fwd_o = wb_wd_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
) (
    input logic           clk,
    input logic           rst,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  mem_re;
        logic                  src0_sel;
        logic                  src1_sel;
        logic [OP_WIDTH-1:0]   alu_op;
        logic [REG_ADDR_W-1:0] ra0;
        logic [REG_ADDR_W-1:0] ra1;
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rd0;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] imm;
    } ex_regs_t;

    ex_regs_t ex_d;
    ex_regs_t ex_q;

    logic [REG_ADDR_W-1:0] fwd_ra  [2];
    logic [DATA_WIDTH-1:0] fwd_rd  [2];
    logic [DATA_WIDTH-1:0] fwd_val [2];

    // Next EX contents: bubble on flush (beats stall), hold on stall, else capture ID.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d        = '0;
            ex_d.alu_op = OP_WIDTH'(ALU_ADD);
        end else if (!bus.stall) begin
            ex_d.valid    = bus.id_valid;
            ex_d.we       = bus.id_we & bus.id_valid;
            ex_d.mem_re   = bus.id_mem_re & bus.id_valid;
            ex_d.src0_sel = bus.id_src0_sel;
            ex_d.src1_sel = bus.id_src1_sel;
            ex_d.alu_op   = bus.id_alu_op;
            ex_d.ra0      = bus.id_ra0;
            ex_d.ra1      = bus.id_ra1;
            ex_d.wa       = bus.id_wa;
            ex_d.pc       = bus.id_pc;
            ex_d.rd0      = bus.id_rd0;
            ex_d.rd1      = bus.id_rd1;
            ex_d.imm      = bus.id_imm;
        end
    end

    // EX state register; reset empties the stage even if it was holding a stalled instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign fwd_ra[0] = ex_q.ra0;
    assign fwd_ra[1] = ex_q.ra1;
    assign fwd_rd[0] = ex_q.rd0;
    assign fwd_rd[1] = ex_q.rd1;

    // One bypass mux per source operand: index 0 is rs1, index 1 is rs2.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        fwd_mux #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fwd_mux (
            .ra_i     (fwd_ra[gi]),
            .rd_i     (fwd_rd[gi]),
            .mem_we_i (bus.mem_we),
            .mem_wa_i (bus.mem_wa),
            .mem_wd_i (bus.mem_wd),
            .wb_we_i  (bus.wb_we),
            .wb_wa_i  (bus.wb_wa),
            .wb_wd_i  (bus.wb_wd),
            .fwd_o    (fwd_val[gi])
        );
    end

    assign bus.alu_src0      = (ex_q.src0_sel == SRC0_PC)  ? ex_q.pc  : fwd_val[0];
    assign bus.alu_src1      = (ex_q.src1_sel == SRC1_IMM) ? ex_q.imm : fwd_val[1];
    assign bus.ex_store_data = fwd_val[1];
    assign bus.alu_op        = ex_q.alu_op;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_we         = ex_q.we;
    assign bus.ex_mem_re     = ex_q.mem_re;
    assign bus.ex_wa         = ex_q.wa;
    assign bus.ex_pc         = ex_q.pc;

    // A load in EX cannot forward its data in time to the instruction now in ID.
    assign bus.load_use = ex_q.valid && ex_q.mem_re && (ex_q.wa != '0) &&
                          ((ex_q.wa == bus.id_ra0) || (ex_q.wa == bus.id_ra1));

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage with an expected-result queue.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    // Vector: ID inputs applied before the edge; bypass inputs and the
    // following ID read addresses (lra0/lra1) applied after it; then expectations.
    typedef struct {
        logic [31:0] stall, flush, valid, pc, rd0, rd1, imm;
        logic [31:0] ra0, ra1, wa, we, mre, op, s0, s1;
        logic [31:0] mwe, mwa, mwd, wwe, wwa, wwd, lra0, lra1;
        logic [31:0] e_src0, e_src1, e_store, e_op, e_valid, e_we, e_mre, e_wa, e_pc, e_lu;
    } vec_t;

    localparam int NVEC = 11;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_checks = 0;
    int     n_errors = 0;
    vec_t   vecs [NVEC];
    vec_t   exp_q [$];

    id_ex_stage_if #(.DATA_WIDTH(32), .OP_WIDTH(5)) bus ();

    id_ex_stage #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, " alu_src0"},      bus.alu_src0,              e.e_src0);
        chk({tag, " alu_src1"},      bus.alu_src1,              e.e_src1);
        chk({tag, " ex_store_data"}, bus.ex_store_data,         e.e_store);
        chk({tag, " alu_op"},        {27'd0, bus.alu_op},       e.e_op);
        chk({tag, " ex_valid"},      {31'd0, bus.ex_valid},     e.e_valid);
        chk({tag, " ex_we"},         {31'd0, bus.ex_we},        e.e_we);
        chk({tag, " ex_mem_re"},     {31'd0, bus.ex_mem_re},    e.e_mre);
        chk({tag, " ex_wa"},         {27'd0, bus.ex_wa},        e.e_wa);
        chk({tag, " ex_pc"},         bus.ex_pc,                 e.e_pc);
        chk({tag, " load_use"},      {31'd0, bus.load_use},     e.e_lu);
    endtask

    task automatic drive_id(input vec_t v);
        bus.stall       = v.stall[0];
        bus.flush       = v.flush[0];
        bus.id_valid    = v.valid[0];
        bus.id_pc       = v.pc;
        bus.id_rd0      = v.rd0;
        bus.id_rd1      = v.rd1;
        bus.id_imm      = v.imm;
        bus.id_ra0      = v.ra0[4:0];
        bus.id_ra1      = v.ra1[4:0];
        bus.id_wa       = v.wa[4:0];
        bus.id_we       = v.we[0];
        bus.id_mem_re   = v.mre[0];
        bus.id_alu_op   = v.op[4:0];
        bus.id_src0_sel = v.s0[0];
        bus.id_src1_sel = v.s1[0];
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        vec_t  e;
        string tag;
        @(negedge clk);
        drive_id(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        bus.mem_we = v.mwe[0];
        bus.mem_wa = v.mwa[4:0];
        bus.mem_wd = v.mwd;
        bus.wb_we  = v.wwe[0];
        bus.wb_wa  = v.wwa[4:0];
        bus.wb_wd  = v.wwd;
        bus.id_ra0 = v.lra0[4:0];
        bus.id_ra1 = v.lra1[4:0];
        #1;
        tag = $sformatf("vec%0d", idx);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e);
        end
        $display("%s: stall=%0d flush=%0d src0=0x%0h src1=0x%0h store=0x%0h op=%0d valid=%0d lu=%0d",
                 tag, v.stall, v.flush, bus.alu_src0, bus.alu_src1, bus.ex_store_data,
                 bus.alu_op, bus.ex_valid, bus.load_use);
    endtask

    initial begin
        vec_t zero_v;
        zero_v = '{default: 32'd0};

        //          st fl v  pc      rd0    rd1    imm    ra0 ra1 wa we mre op        s0 s1  mwe mwa mwd       wwe wwa wwd       lra0 lra1  src0     src1   store     op        v  we mre wa pc      lu
        vecs[0]  = '{0, 0, 1, 'h100, 5,     7,     0,     1,  2,  3, 1, 0, ALU_ADD,  0, 0,  0,  0,  0,        0,  0,  0,        1,   2,    5,       7,     7,        ALU_ADD,  1, 1, 0,  3, 'h100, 0};
        vecs[1]  = '{0, 0, 1, 'h104, 'h11,  'h22,  'h30,  3,  4,  6, 1, 0, ALU_SUB,  0, 1,  1,  3,  'hAA,     1,  3,  'hBB,     0,   0,    'hAA,    'h30,  'h22,     ALU_SUB,  1, 1, 0,  6, 'h104, 0};
        vecs[2]  = '{1, 0, 1, 'h200, 'h99,  'h98,  'h97,  3,  4, 10, 1, 1, ALU_SLT,  1, 1,  0,  3,  'hAA,     1,  3,  'hBB,     3,   4,    'hBB,    'h30,  'h22,     ALU_SUB,  1, 1, 0,  6, 'h104, 0};
        vecs[3]  = '{0, 0, 1, 'h108, 1,     0,     0,     0,  0,  7, 1, 0, ALU_OR,   1, 0,  1,  0,  'hFF,     1,  0,  'hEE,     0,   0,    'h108,   0,     0,        ALU_OR,   1, 1, 0,  7, 'h108, 0};
        vecs[4]  = '{0, 0, 1, 'h10C, 'h40,  'h50,  4,     8,  9,  5, 1, 1, ALU_ADD,  0, 1,  1,  8,  'h1234,   1,  9,  'h5678,   0,   5,    'h1234,  4,     'h5678,   ALU_ADD,  1, 1, 1,  5, 'h10C, 1};
        vecs[5]  = '{1, 0, 1, 'h600, 1,     2,     3,     6,  6,  6, 1, 0, ALU_SUB,  0, 0,  0,  0,  0,        0,  0,  0,        6,   6,    'h40,    4,     'h50,     ALU_ADD,  1, 1, 1,  5, 'h10C, 0};
        vecs[6]  = '{1, 0, 1, 'h600, 1,     2,     3,     6,  6,  6, 1, 0, ALU_SUB,  0, 0,  1,  9,  'h77,     1,  9,  'h88,     5,   0,    'h40,    4,     'h77,     ALU_ADD,  1, 1, 1,  5, 'h10C, 1};
        vecs[7]  = '{0, 1, 1, 'h300, 'h31,  'h32,  'h33,  1,  2,  3, 1, 1, ALU_SRC0, 0, 0,  0,  0,  0,        0,  0,  0,        0,   0,    0,       0,     0,        ALU_ADD,  0, 0, 0,  0, 0,     0};
        vecs[8]  = '{0, 0, 1, 'h304, 'h0F,  'hF0,  8,     12, 13, 14,1, 0, ALU_XOR,  0, 0,  0,  0,  0,        0,  0,  0,        0,   0,    'h0F,    'hF0,  'hF0,     ALU_XOR,  1, 1, 0, 14, 'h304, 0};
        vecs[9]  = '{1, 1, 1, 'h308, 1,     2,     3,     4,  5,  6, 1, 1, ALU_SRA,  1, 1,  0,  0,  0,        0,  0,  0,        0,   0,    0,       0,     0,        ALU_ADD,  0, 0, 0,  0, 0,     0};
        vecs[10] = '{0, 0, 0, 'h400, 3,     4,     0,     1,  2,  9, 1, 1, ALU_SLT,  0, 0,  0,  0,  0,        0,  0,  0,        9,   9,    3,       4,     4,        ALU_SLT,  0, 0, 0,  9, 'h400, 0};

        // Reset with all inputs quiet.
        drive_id(zero_v);
        bus.mem_we = 1'b0; bus.mem_wa = '0; bus.mem_wd = '0;
        bus.wb_we  = 1'b0; bus.wb_wa  = '0; bus.wb_wd  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", zero_v);
        $display("reset: valid=%0d op=%0d pc=0x%0h", bus.ex_valid, bus.alu_op, bus.ex_pc);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply_vec(vecs[i], i);
        end

        // Reset arriving while a valid load is held by stall must leave the stage empty.
        begin
            vec_t ld;
            ld = zero_v;
            ld.valid = 1; ld.pc = 'h500; ld.rd0 = 'h55; ld.rd1 = 'h66; ld.imm = 'h8;
            ld.wa = 5; ld.we = 1; ld.mre = 1; ld.op = ALU_SLL; ld.s0 = 1;
            @(negedge clk);
            drive_id(ld);
            bus.mem_we = 1'b0; bus.wb_we = 1'b0;
            @(posedge clk);
            #1;
            chk("rststall pre ex_valid", {31'd0, bus.ex_valid}, 32'd1);
            chk("rststall pre ex_pc",    bus.ex_pc,             32'h500);
            $display("rststall pre: valid=%0d pc=0x%0h", bus.ex_valid, bus.ex_pc);
            @(negedge clk);
            bus.stall = 1'b1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("rststall during ex_valid", {31'd0, bus.ex_valid}, 32'd0);
            $display("rststall during: valid=%0d", bus.ex_valid);
            @(negedge clk);
            rst = 1'b0;
            bus.id_ra0 = 5'd5;
            bus.id_ra1 = 5'd5;
            @(posedge clk);
            #1;
            check_outputs("rststall post", zero_v);
            $display("rststall post: valid=%0d pc=0x%0h src0=0x%0h lu=%0d",
                     bus.ex_valid, bus.ex_pc, bus.alu_src0, bus.load_use);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter OP_WIDTH, default 5, ALU opcode width.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have stall  input  1  hold all ID/EX state; flush  input  1  insert bubble.
REQ-006 SHALL have ID-side inputs: id_valid 1; id_pc, id_rd0, id_rd1, id_imm DATA_WIDTH each; id_ra0, id_ra1, id_wa 5 each; id_we 1; id_mem_re 1; id_alu_op OP_WIDTH; id_src0_sel 1 (0 rs1, 1 pc); id_src1_sel 1 (0 rs2, 1 imm).
REQ-007 SHALL have bypass inputs: mem_we 1, mem_wa 5, mem_wd DATA_WIDTH; wb_we 1, wb_wa 5, wb_wd DATA_WIDTH.
REQ-008 SHALL have outputs: alu_src0, alu_src1 DATA_WIDTH; alu_op OP_WIDTH; ex_valid, ex_we, ex_mem_re 1 each; ex_wa 5; ex_pc DATA_WIDTH; ex_store_data DATA_WIDTH (forwarded rs2); load_use 1.

Function
REQ-009 SHALL register all ID-side inputs into the EX stage on each rising edge when rst=0, stall=0, flush=0 (latency 1 cycle).
REQ-010 SHALL, when flush=1, load a bubble next edge: ex_valid=0, ex_we=0, ex_mem_re=0, alu_op=5'b00000 (ADD), ex_wa=0, all data registers 0.
REQ-011 SHALL, when stall=1 and flush=0, hold every EX register unchanged.
REQ-012 SHALL give flush priority over stall when both asserted in the same cycle.
REQ-013 SHALL compute forwarded rs1/rs2 combinationally from registered ra0/ra1: MEM match (mem_we=1, mem_wa!=0, mem_wa==ra) selects mem_wd; else WB match selects wb_wd; else registered rd value.
REQ-014 SHALL never forward when the register address is 0; x0 reads return the registered value.
REQ-015 SHALL give MEM-stage bypass priority over WB-stage bypass when both match.
REQ-016 SHALL drive alu_src0 = ex_pc if src0_sel=1 else forwarded rs1; alu_src1 = ex_imm if src1_sel=1 else forwarded rs2.
REQ-017 SHALL drive ex_store_data = forwarded rs2 regardless of src1_sel.
REQ-018 SHALL assert load_use combinationally when ex_valid=1, ex_mem_re=1, ex_wa!=0 and ex_wa equals id_ra0 or id_ra1; upstream converts this to stall of IF/ID plus flush of this stage.
REQ-019 SHALL register ex_valid from id_valid; ex_we and ex_mem_re registered as id_we&id_valid and id_mem_re&id_valid.
REQ-020 SHALL pass alu_op unchanged; opcode decoding is owned by the ALU.

Reset
REQ-021 SHALL, on rst=1 at a rising edge, clear all EX registers to 0 (equivalent to a bubble, alu_op=ADD), overriding stall and flush.
REQ-022 SHALL, when reset asserts mid-stall, leave the stage empty after reset release, no held instruction retained.

Structure
REQ-023 SHALL take ALU opcode encodings (ADD 00000, SUB 00010, SLT 00100, SLTU 00101, AND 01001, OR 01010, XOR 01011, SLL 01110, SRL 01111, SRA 10000, SRC0 10001, SRC1 10010) and the src-select constants from a shared CPU package.
REQ-024 SHALL place the two-level bypass selection in one sub-module, fwd_mux, instantiated twice (rs1, rs2).

Verification
REQ-025 Plain issue: id_rd0=5, id_rd1=7, alu_op=ADD, no bypass -> next cycle alu_src0=5, alu_src1=7, ex_valid=1.
REQ-026 Double bypass: ra0=3, mem_we=1 mem_wa=3 mem_wd=0xAA, wb_we=1 wb_wa=3 wb_wd=0xBB -> alu_src0=0xAA; drop mem_we -> 0xBB.
REQ-027 x0 guard: ra1=0, mem_we=1 mem_wa=0 mem_wd=0xFF, id_rd1=0 -> alu_src1=0.
REQ-028 Stall+flush same cycle with valid instruction pending -> next cycle ex_valid=0, ex_we=0, alu_op=00000.
REQ-029 Load-use: EX holds load to x5 (ex_mem_re=1), ID ra1=5 -> load_use=1; ID ra0=ra1=6 -> load_use=0.
REQ-030 Reset during stall with ex_valid=1 -> after edge all outputs 0 except combinational forwarding of zeroed registers.
